// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared state type and constants for the USB full-speed transmit path.
package usb_tx_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, DATA, CRC, EOP_SE0, EOP_J} tx_state_t;
  localparam logic [7:0]  SYNC_PATTERN   = 8'b1000_0000;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  function automatic logic crc16_residual_ok(input logic [15:0] crc);
    return crc == CRC16_RESIDUAL;
  endfunction
endpackage

// File: rtl/usb_tx_ctrl_crc16.sv
// usb_crc16: serial CRC-16 (poly 0x8005), MSB-of-register form; the register read MSB-first is the LSB-first wire order.
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);
  logic [15:0] r_crc;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_crc <= CRC16_INIT;
    else if (i_init) r_crc <= CRC16_INIT;
    else if (i_en) r_crc <= {r_crc[14:0], 1'b0} ^ ((i_bit ^ r_crc[15]) ? CRC16_POLY : 16'h0000);
  assign o_crc = r_crc;
endmodule

// File: rtl/usb_tx_ctrl.sv
// usb_tx_ctrl: USB FS transmit sequencer emitting SYNC, bit-stuffed LSB-first payload and EOP.
// Define USB_TX_CRC16_EN to append the complemented CRC16 of the non-PID bytes before EOP.
module usb_tx_ctrl
  import usb_tx_pkg::*;
#(
  parameter int SYNC_BITS    = 8,
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_en,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       bit_out,
  output logic       bit_stb,
  output logic       se0,
  output logic       tx_active,
  output logic       tx_done,
  output logic       underrun
);
  tx_state_t  r_state;
  logic [7:0] r_shreg;
  logic [7:0] r_bit_cnt;
  logic [7:0] r_ones_cnt;
  logic       r_last;
  logic       r_bit_out;
  logic       r_bit_stb;
  logic       r_se0;
  logic       r_tx_active;
  logic       r_tx_done;
  logic       r_underrun;
  logic       w_stuff;
  logic       w_adv;
  logic       w_emit;
  logic       w_byte_end;
  logic       w_sync_bit;
  logic       w_crc_bit;
  logic       w_to_crc;
  logic       w_tx_bit;
  assign w_stuff    = (r_ones_cnt == 8'(STUFF_LEN)) && (r_state != SYNC);
  assign w_adv      = bit_en && !w_stuff;
  assign w_byte_end = (r_state == DATA) && w_adv && (r_bit_cnt == 8'd7);
  assign w_sync_bit = (SYNC_BITS == 8) ? SYNC_PATTERN[r_bit_cnt[2:0]] : (r_bit_cnt == 8'(SYNC_BITS - 1));
  assign w_tx_bit   = (r_state == SYNC) ? w_sync_bit : (r_state == CRC) ? w_crc_bit : r_shreg[0];
  // a pending stuff bit is still owed after the last payload bit, before SE0 starts
  assign w_emit     = bit_en && ((r_state == SYNC) || (r_state == DATA) || (r_state == CRC) || (r_state == EOP_SE0 && w_stuff));
  assign in_ready   = (r_state == IDLE) ? in_valid : (w_byte_end && !r_last && in_valid);
`ifdef USB_TX_CRC16_EN
  logic        r_pid;
  logic [15:0] w_crc;
  usb_crc16 u_crc (
    .clk    (clk),
    .rst    (rst),
    .i_init (r_state == IDLE),
    .i_en   ((r_state == DATA) && w_adv && !r_pid),
    .i_bit  (r_shreg[0]),
    .o_crc  (w_crc)
  );
  assign w_crc_bit = ~w_crc[4'd15 - r_bit_cnt[3:0]];
  assign w_to_crc  = !r_pid;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_pid <= 1'b0;
    else if (in_ready) r_pid <= (r_state == IDLE);
`else
  assign w_crc_bit = 1'b0;
  assign w_to_crc  = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_ones_cnt  <= '0;
      r_last      <= 1'b0;
      r_bit_out   <= 1'b0;
      r_bit_stb   <= 1'b0;
      r_se0       <= 1'b0;
      r_tx_active <= 1'b0;
      r_tx_done   <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_bit_stb  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_underrun <= 1'b0;
      if (w_emit) begin
        r_bit_stb  <= 1'b1;
        r_bit_out  <= w_stuff ? 1'b0 : w_tx_bit;
        r_ones_cnt <= (!w_stuff && w_tx_bit) ? r_ones_cnt + 8'd1 : 8'd0;
      end
      case (r_state)
        IDLE: if (in_valid) begin
          r_state     <= SYNC;
          r_bit_cnt   <= '0;
          r_ones_cnt  <= '0;
          r_tx_active <= 1'b1;
        end
        SYNC: if (bit_en) begin
          r_bit_cnt <= (r_bit_cnt == 8'(SYNC_BITS - 1)) ? 8'd0 : r_bit_cnt + 8'd1;
          if (r_bit_cnt == 8'(SYNC_BITS - 1)) r_state <= DATA;
        end
        DATA: if (w_adv) begin
          r_shreg   <= {1'b0, r_shreg[7:1]};
          r_bit_cnt <= (r_bit_cnt == 8'd7) ? 8'd0 : r_bit_cnt + 8'd1;
          if (r_bit_cnt == 8'd7 && r_last) r_state <= w_to_crc ? CRC : EOP_SE0;
          else if (r_bit_cnt == 8'd7 && !in_valid) begin
            r_underrun <= 1'b1;
            r_state    <= EOP_SE0;
          end
        end
        CRC: if (w_adv) begin
          r_bit_cnt <= (r_bit_cnt == 8'd15) ? 8'd0 : r_bit_cnt + 8'd1;
          if (r_bit_cnt == 8'd15) r_state <= EOP_SE0;
        end
        EOP_SE0: if (w_adv) begin
          r_se0     <= 1'b1;
          r_bit_cnt <= r_bit_cnt + 8'd1;
          if (r_bit_cnt == 8'(EOP_SE0_BITS - 1)) r_state <= EOP_J;
        end
        EOP_J: if (bit_en) begin
          r_se0       <= 1'b0;
          r_tx_done   <= 1'b1;
          r_tx_active <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (in_ready) begin
        r_shreg   <= in_data;
        r_last    <= in_last;
        r_bit_cnt <= '0;
      end
    end
  assign bit_out   = r_bit_out;
  assign bit_stb   = r_bit_stb;
  assign se0       = r_se0;
  assign tx_active = r_tx_active;
  assign tx_done   = r_tx_done;
  assign underrun  = r_underrun;
endmodule
